// File: rtl/keccak_xif_offload_ctrl.sv
// keccak_xif_offload_ctrl
// Core-side initiator for the CORE-V-XIF issue/commit/result channels.
// The block takes one decoded custom instruction from the pipeline, issues it
// to the Keccak coprocessor, commits or kills it, and collects the result.
// It then returns writeback and status information to the pipeline.
// Only one instruction is outstanding at a time. XIF IDs increment by one
// for every issued instruction and wrap modulo 2**X_ID_WIDTH.
//
// Optional feature: define KECCAK_XIF_TIMEOUT_EN to enable a result watchdog.
// The watchdog ends WAIT_RES with status 11 after TIMEOUT_CYCLES cycles.
//
// Handshake rule for every valid/ready pair below: a transfer happens in a
// cycle where both valid and ready are high. Once valid is raised, the
// initiator holds valid and its payload stable until that transfer happens.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   instr_valid_i/instr_ready_o    pipeline request handshake
//   instr_i, rs1_i, rs2_i          instruction word and source operands
//   flush_i                        pipeline kill of the in-flight instruction
//   x_issue_*                      XIF issue channel (initiator side)
//   x_commit_*                     XIF commit channel (one-cycle pulse)
//   x_result_*                     XIF result channel (we provide ready)
//   done_*                         completion pulse back to the pipeline
//                                  status: 00 ok, 01 not accepted, 10 killed,
//                                  11 exception / ID error / timeout
//   busy_o                         controller not idle
//   dbg_state_o                    current FSM state, for debug and checkers
module keccak_xif_offload_ctrl #(
  parameter int X_ID_WIDTH     = 4,
  parameter int X_RFR_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     instr_valid_i,
  output logic                     instr_ready_o,
  input  logic [31:0]              instr_i,
  input  logic [X_RFR_WIDTH-1:0]   rs1_i,
  input  logic [X_RFR_WIDTH-1:0]   rs2_i,
  input  logic                     flush_i,
  output logic                     x_issue_valid_o,
  input  logic                     x_issue_ready_i,
  output logic [31:0]              x_issue_instr_o,
  output logic [X_ID_WIDTH-1:0]    x_issue_id_o,
  output logic [2*X_RFR_WIDTH-1:0] x_issue_rs_o,
  output logic [1:0]               x_issue_rs_valid_o,
  input  logic                     x_issue_accept_i,
  input  logic                     x_issue_writeback_i,
  output logic                     x_commit_valid_o,
  output logic [X_ID_WIDTH-1:0]    x_commit_id_o,
  output logic                     x_commit_kill_o,
  input  logic                     x_result_valid_i,
  output logic                     x_result_ready_o,
  input  logic [X_ID_WIDTH-1:0]    x_result_id_i,
  input  logic [X_RFR_WIDTH-1:0]   x_result_data_i,
  input  logic [4:0]               x_result_rd_i,
  input  logic                     x_result_we_i,
  input  logic                     x_result_exc_i,
  output logic                     done_valid_o,
  output logic                     done_we_o,
  output logic [4:0]               done_rd_o,
  output logic [X_RFR_WIDTH-1:0]   done_data_o,
  output logic [1:0]               done_status_o,
  output logic                     busy_o,
  output logic [2:0]               dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_COMMIT   = 3'd2,
    S_WAIT_RES = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            instr_q;
  logic [X_RFR_WIDTH-1:0] rs1_q, rs2_q;
  logic [X_ID_WIDTH-1:0]  id_cnt_q, issued_id_q;
  logic                   accept_q, writeback_q, flush_seen_q;
  logic                   done_we_q;
  logic [4:0]             done_rd_q;
  logic [X_RFR_WIDTH-1:0] done_data_q;
  logic [1:0]             done_status_q;
  logic                   timeout_hit;
  logic                   issue_hs, result_hs, killed_now;

  assign issue_hs   = (state_q == S_ISSUE) && x_issue_ready_i;
  assign result_hs  = (state_q == S_WAIT_RES) && x_result_valid_i;
  // A flush arriving in the same cycle as the result still kills it.
  assign killed_now = flush_seen_q || flush_i;

`ifdef KECCAK_XIF_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;

  // Counts completed WAIT_RES cycles. Restarts every time WAIT_RES is entered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
    end else if (state_q == S_WAIT_RES) begin
      tmo_cnt_q <= tmo_cnt_q + 32'd1;
    end else begin
      tmo_cnt_q <= '0;
    end
  end

  assign timeout_hit = (state_q == S_WAIT_RES) &&
                       (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign timeout_hit        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_d            = state_q;
    instr_ready_o      = 1'b0;
    x_issue_valid_o    = 1'b0;
    x_issue_rs_valid_o = 2'b00;
    x_commit_valid_o   = 1'b0;
    x_result_ready_o   = 1'b0;
    done_valid_o       = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready_o = 1'b1;
        if (instr_valid_i) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        x_issue_valid_o    = 1'b1;
        x_issue_rs_valid_o = 2'b11;
        if (x_issue_ready_i) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        x_commit_valid_o = 1'b1;
        // A killed but accepted instruction still returns a result, which we drain.
        state_d = accept_q ? S_WAIT_RES : S_DONE;
      end
      S_WAIT_RES: begin
        x_result_ready_o = 1'b1;
        if (x_result_valid_i || timeout_hit) state_d = S_DONE;
      end
      S_DONE: begin
        done_valid_o = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The issue payload is driven only while issuing, so it reads as zero otherwise.
  assign x_issue_instr_o = (state_q == S_ISSUE) ? instr_q : '0;
  assign x_issue_id_o    = (state_q == S_ISSUE) ? id_cnt_q : '0;
  assign x_issue_rs_o    = (state_q == S_ISSUE) ? {rs2_q, rs1_q} : '0;
  assign x_commit_id_o   = (state_q == S_COMMIT) ? issued_id_q : '0;
  assign x_commit_kill_o = (state_q == S_COMMIT) && (flush_seen_q || !accept_q);
  assign done_we_o       = (state_q == S_DONE) && done_we_q;
  assign done_rd_o       = done_rd_q;
  assign done_data_o     = done_data_q;
  assign done_status_o   = done_status_q;
  assign busy_o          = (state_q != S_IDLE);
  assign dbg_state_o     = state_q;

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_q       <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      id_cnt_q      <= '0;
      issued_id_q   <= '0;
      accept_q      <= 1'b0;
      writeback_q   <= 1'b0;
      flush_seen_q  <= 1'b0;
      done_we_q     <= 1'b0;
      done_rd_q     <= '0;
      done_data_q   <= '0;
      done_status_q <= 2'b00;
    end else begin
      if ((state_q == S_IDLE) && instr_valid_i) begin
        instr_q <= instr_i;
        rs1_q   <= rs1_i;
        rs2_q   <= rs2_i;
      end

      if (issue_hs) begin
        accept_q    <= x_issue_accept_i;
        writeback_q <= x_issue_writeback_i;
        issued_id_q <= id_cnt_q;
        id_cnt_q    <= id_cnt_q + X_ID_WIDTH'(1);
      end

      // flush_seen is sticky while an instruction is in flight and clears when the FSM returns to IDLE.
      if (state_q == S_DONE) begin
        flush_seen_q <= 1'b0;
      end else if (flush_i && ((state_q == S_ISSUE) || (state_q == S_COMMIT) ||
                               (state_q == S_WAIT_RES))) begin
        flush_seen_q <= 1'b1;
      end

      if ((state_q == S_COMMIT) && !accept_q) begin
        done_status_q <= 2'b01;
        done_we_q     <= 1'b0;
        done_rd_q     <= '0;
        done_data_q   <= '0;
      end

      if (result_hs) begin
        done_data_q <= x_result_data_i;
        done_rd_q   <= x_result_rd_i;
        if ((x_result_id_i != issued_id_q) || x_result_exc_i) begin
          done_status_q <= 2'b11;
          done_we_q     <= 1'b0;
        end else if (killed_now) begin
          done_status_q <= 2'b10;
          done_we_q     <= 1'b0;
        end else begin
          done_status_q <= 2'b00;
          done_we_q     <= x_result_we_i && writeback_q;
        end
      end else if (timeout_hit) begin
        done_status_q <= 2'b11;
        done_we_q     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keccak_xif_offload_ctrl.sv
module tb_keccak_xif_offload_ctrl;
  localparam int IDW = 4;
  localparam int RW  = 32;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            instr_valid_i = 1'b0;
  logic            instr_ready_o;
  logic [31:0]     instr_i = '0;
  logic [RW-1:0]   rs1_i = '0, rs2_i = '0;
  logic            flush_i = 1'b0;
  logic            x_issue_valid_o;
  logic            x_issue_ready_i = 1'b0;
  logic [31:0]     x_issue_instr_o;
  logic [IDW-1:0]  x_issue_id_o;
  logic [2*RW-1:0] x_issue_rs_o;
  logic [1:0]      x_issue_rs_valid_o;
  logic            x_issue_accept_i = 1'b0;
  logic            x_issue_writeback_i = 1'b0;
  logic            x_commit_valid_o;
  logic [IDW-1:0]  x_commit_id_o;
  logic            x_commit_kill_o;
  logic            x_result_valid_i = 1'b0;
  logic            x_result_ready_o;
  logic [IDW-1:0]  x_result_id_i = '0;
  logic [RW-1:0]   x_result_data_i = '0;
  logic [4:0]      x_result_rd_i = '0;
  logic            x_result_we_i = 1'b0;
  logic            x_result_exc_i = 1'b0;
  logic            done_valid_o, done_we_o;
  logic [4:0]      done_rd_o;
  logic [RW-1:0]   done_data_o;
  logic [1:0]      done_status_o;
  logic            busy_o;
  logic [2:0]      dbg_state_unused;

  int n_checks = 0;
  int n_fail   = 0;
  int model_id = 0;
  logic [IDW-1:0] exp_q[$];

  keccak_xif_offload_ctrl #(.X_ID_WIDTH(IDW), .X_RFR_WIDTH(RW), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .instr_i(instr_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i),
    .x_issue_valid_o(x_issue_valid_o), .x_issue_ready_i(x_issue_ready_i),
    .x_issue_instr_o(x_issue_instr_o), .x_issue_id_o(x_issue_id_o),
    .x_issue_rs_o(x_issue_rs_o), .x_issue_rs_valid_o(x_issue_rs_valid_o),
    .x_issue_accept_i(x_issue_accept_i), .x_issue_writeback_i(x_issue_writeback_i),
    .x_commit_valid_o(x_commit_valid_o), .x_commit_id_o(x_commit_id_o),
    .x_commit_kill_o(x_commit_kill_o),
    .x_result_valid_i(x_result_valid_i), .x_result_ready_o(x_result_ready_o),
    .x_result_id_i(x_result_id_i), .x_result_data_i(x_result_data_i),
    .x_result_rd_i(x_result_rd_i), .x_result_we_i(x_result_we_i),
    .x_result_exc_i(x_result_exc_i),
    .done_valid_o(done_valid_o), .done_we_o(done_we_o), .done_rd_o(done_rd_o),
    .done_data_o(done_data_o), .done_status_o(done_status_o), .busy_o(busy_o),
    .dbg_state_o(dbg_state_unused)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    instr_valid_i = 1'b0; flush_i = 1'b0; x_issue_ready_i = 1'b0;
    x_issue_accept_i = 1'b0; x_issue_writeback_i = 1'b0; x_result_valid_i = 1'b0;
    x_result_exc_i = 1'b0; x_result_we_i = 1'b0;
    repeat (3) tick();
    rst_ni = 1'b1;
    model_id = 0;
    exp_q.delete();
    tick();
  endtask

  // One complete instruction. The expected outcome is derived from the
  // transaction parameters alone.
  task automatic run_txn(input logic acc, input logic wb, input int rdy_dly,
                         input bit fl_issue, input int res_dly, input bit bad_id,
                         input logic exc, input logic we, input bit fl_res,
                         input logic [31:0] data, input logic [4:0] rd);
    logic [31:0]    ins, a, b;
    logic [IDW-1:0] eid;
    logic [1:0]     est;
    logic           ewe;
    int             guard;
    ins = $urandom; a = $urandom; b = $urandom;
    exp_q.push_back(IDW'(model_id));
    model_id = (model_id + 1) % (1 << IDW);
    if (!acc)                    begin est = 2'b01; ewe = 1'b0; end
    else if (bad_id || exc)      begin est = 2'b11; ewe = 1'b0; end
    else if (fl_issue || fl_res) begin est = 2'b10; ewe = 1'b0; end
    else                         begin est = 2'b00; ewe = we & wb; end

    guard = 0;
    while (!instr_ready_o && guard < 20) begin tick(); guard++; end
    n_checks++;
    if (instr_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL idle_ready actual=%b required=1", instr_ready_o);
    end
    instr_valid_i = 1'b1; instr_i = ins; rs1_i = a; rs2_i = b;
    tick();
    instr_valid_i = 1'b0; instr_i = $urandom; rs1_i = $urandom; rs2_i = $urandom;
    eid = exp_q[0];
    flush_i = fl_issue;
    for (int k = 0; k <= rdy_dly; k++) begin
      n_checks++;
      if ({x_issue_valid_o, x_issue_rs_valid_o, x_issue_id_o, x_issue_instr_o, x_issue_rs_o,
           busy_o, instr_ready_o} !== {1'b1, 2'b11, eid, ins, b, a, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL issue_hold cyc=%0d actual v=%b id=%0d instr=%h rs=%h required v=1 id=%0d instr=%h rs=%h",
                 k, x_issue_valid_o, x_issue_id_o, x_issue_instr_o, x_issue_rs_o, eid, ins, {b, a});
      end
      if (k == rdy_dly) begin
        x_issue_ready_i = 1'b1; x_issue_accept_i = acc; x_issue_writeback_i = wb;
      end
      tick();
      flush_i = 1'b0;
    end
    x_issue_ready_i = 1'b0; x_issue_accept_i = 1'b0; x_issue_writeback_i = 1'b0;

    eid = exp_q.pop_front();
    n_checks++;
    if ({x_commit_valid_o, x_commit_id_o, x_commit_kill_o, x_issue_valid_o, x_result_ready_o} !==
        {1'b1, eid, (fl_issue | ~acc), 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL commit actual v=%b id=%0d kill=%b iv=%b rr=%b required v=1 id=%0d kill=%b iv=0 rr=0",
               x_commit_valid_o, x_commit_id_o, x_commit_kill_o, x_issue_valid_o, x_result_ready_o,
               eid, (fl_issue | ~acc));
    end
    tick();

    if (acc) begin
      for (int k = 0; k <= res_dly; k++) begin
        n_checks++;
        if ({x_result_ready_o, done_valid_o, x_commit_valid_o} !== 3'b100) begin
          n_fail++;
          $display("FAIL wait_res cyc=%0d actual rr=%b dv=%b cv=%b required rr=1 dv=0 cv=0",
                   k, x_result_ready_o, done_valid_o, x_commit_valid_o);
        end
        if (k == res_dly) begin
          x_result_valid_i = 1'b1;
          x_result_id_i = bad_id ? IDW'(eid + 1'b1) : eid;
          x_result_data_i = data; x_result_rd_i = rd; x_result_we_i = we;
          x_result_exc_i = exc; flush_i = fl_res;
        end
        tick();
      end
      x_result_valid_i = 1'b0; x_result_exc_i = 1'b0; x_result_we_i = 1'b0;
      flush_i = 1'b0; x_result_data_i = $urandom; x_result_rd_i = 5'($urandom);
    end

    n_checks++;
    if ({done_valid_o, done_status_o, done_we_o, x_result_ready_o, busy_o} !==
        {1'b1, est, ewe, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL done actual dv=%b st=%b we=%b rr=%b busy=%b required dv=1 st=%b we=%b rr=0 busy=1",
               done_valid_o, done_status_o, done_we_o, x_result_ready_o, busy_o, est, ewe);
    end
    if (acc) begin
      n_checks++;
      if ({done_rd_o, done_data_o} !== {rd, data}) begin
        n_fail++;
        $display("FAIL done_data actual rd=%0d data=%h required rd=%0d data=%h",
                 done_rd_o, done_data_o, rd, data);
      end
    end
    tick();
    n_checks++;
    if ({done_valid_o, busy_o, instr_ready_o} !== 3'b001) begin
      n_fail++;
      $display("FAIL back_idle actual dv=%b busy=%b ir=%b required dv=0 busy=0 ir=1",
               done_valid_o, busy_o, instr_ready_o);
    end
  endtask

  // Tests
  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({instr_ready_o, x_issue_valid_o, x_issue_id_o, x_issue_rs_valid_o, x_commit_valid_o,
         x_commit_kill_o, x_result_ready_o, done_valid_o, done_we_o, done_status_o, busy_o} !==
        {1'b1, 1'b0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs actual ir=%b iv=%b cv=%b rr=%b dv=%b busy=%b required ir=1 others 0",
               instr_ready_o, x_issue_valid_o, x_commit_valid_o, x_result_ready_o, done_valid_o, busy_o);
    end
  endtask

  task automatic test_basic();
    run_txn(1'b1, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 5'd5);
  endtask

  task automatic test_not_accepted();
    run_txn(1'b0, 1'b1, 1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0);
  endtask

  task automatic test_flush_issue();
    run_txn(1'b1, 1'b1, 3, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h12345678, 5'd9);
  endtask

  task automatic test_flush_at_result();
    run_txn(1'b1, 1'b1, 0, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b1, 32'hCAFEF00D, 5'd3);
  endtask

  task automatic test_errors();
    run_txn(1'b1, 1'b1, 0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h11111111, 5'd7);
    run_txn(1'b1, 1'b1, 1, 1'b0, 1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h22222222, 5'd8);
  endtask

  task automatic test_flush_idle();
    flush_i = 1'b1;
    tick(); tick();
    flush_i = 1'b0;
    n_checks++;
    if ({busy_o, instr_ready_o} !== 2'b01) begin
      n_fail++; $display("FAIL flush_idle actual busy=%b ir=%b required busy=0 ir=1", busy_o, instr_ready_o);
    end
    run_txn(1'b1, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA5A5A5A5, 5'd31);
  endtask

  task automatic test_reset_mid_op();
    instr_valid_i = 1'b1; instr_i = $urandom;
    tick();
    instr_valid_i = 1'b0;
    x_issue_ready_i = 1'b1; x_issue_accept_i = 1'b1;
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if ({x_issue_valid_o, busy_o, instr_ready_o} !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_abort actual iv=%b busy=%b ir=%b required iv=0 busy=0 ir=1",
               x_issue_valid_o, busy_o, instr_ready_o);
    end
    tick();
    n_checks++;
    if (x_commit_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_commit actual=%b required=0", x_commit_valid_o);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 17; i++)
      run_txn(1'b1, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, $urandom, 5'($urandom));
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      run_txn($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 4) == 0, $urandom_range(0, 4), $urandom_range(0, 5) == 0,
              $urandom_range(0, 5) == 0, 1'($urandom), $urandom_range(0, 4) == 0,
              $urandom, 5'($urandom));
  endtask

`ifdef KECCAK_XIF_TIMEOUT_EN
  task automatic test_timeout();
    int waits;
    instr_valid_i = 1'b1; instr_i = $urandom;
    tick();
    instr_valid_i = 1'b0; x_issue_ready_i = 1'b1; x_issue_accept_i = 1'b1;
    tick();
    x_issue_ready_i = 1'b0; x_issue_accept_i = 1'b0;
    model_id = (model_id + 1) % (1 << IDW);
    tick();
    waits = 0;
    while (x_result_ready_o && waits < 40) begin tick(); waits++; end
    n_checks++;
    if ({waits, done_valid_o, done_status_o, done_we_o} !== {32'd8, 1'b1, 2'b11, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout actual waits=%0d dv=%b st=%b we=%b required waits=8 dv=1 st=11 we=0",
               waits, done_valid_o, done_status_o, done_we_o);
    end
    tick();
    n_checks++;
    if ({busy_o, x_result_ready_o} !== 2'b00) begin
      n_fail++; $display("FAIL timeout_idle actual busy=%b rr=%b required 0 0", busy_o, x_result_ready_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_not_accepted();
    test_flush_issue();
    test_flush_at_result();
    test_errors();
    test_flush_idle();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
`ifdef KECCAK_XIF_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
